// File: rtl/axi_pkg.sv
// Shared AXI types used by the decode-error responder.
// - resp_t: 2-bit B/R response code with the four standard encodings.
// - len_t:  8-bit AXI burst length (number of beats minus one).
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef logic [7:0] len_t;

endpackage

// File: rtl/axi_decerr_slave.sv
// Terminal AXI responder for requests that match no slave. Every write burst
// is accepted, its data discarded, and answered with a single B carrying RESP.
// Every read burst returns len+1 beats of the constant RDATA with RESP. One
// outstanding transaction per direction; write and read sides are independent.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   aw_id_i/aw_valid_i/aw_ready_o           write address channel
//   w_last_i/w_valid_i/w_ready_o            write data channel (payload unused)
//   b_id_o/b_resp_o/b_valid_o/b_ready_i     write response channel
//   ar_id_i/ar_len_i/ar_valid_i/ar_ready_o  read address channel
//   r_id_o/r_data_o/r_resp_o/r_last_o/r_valid_o/r_ready_i  read data channel
//   wr_err_cnt_o, rd_err_cnt_o              saturating completed-burst counters
module axi_decerr_slave
    import axi_pkg::*;
#(
    parameter int unsigned             ID_WIDTH   = 4,
    parameter int unsigned             DATA_WIDTH = 64,
    parameter resp_t                   RESP       = RESP_DECERR,
    parameter logic [DATA_WIDTH-1:0]   RDATA      = '0,
    parameter int unsigned             CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,

    input  logic                  w_last_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,

    output logic [ID_WIDTH-1:0]   b_id_o,
    output resp_t                 b_resp_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,

    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  len_t                  ar_len_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,

    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output resp_t                 r_resp_o,
    output logic                  r_last_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,

    output logic [CNT_WIDTH-1:0]  wr_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  rd_err_cnt_o
);

    typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
    typedef enum logic       {RdIdle, RdData}         rd_state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   wr_id_q,    wr_id_d;
    logic [ID_WIDTH-1:0]   rd_id_q,    rd_id_d;
    len_t                  beat_q,     beat_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q,   wr_cnt_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q,   rd_cnt_d;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        wr_cnt_d   = wr_cnt_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;

        unique case (wr_state_q)
            WrIdle: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) begin
                    wr_id_d    = aw_id_i;
                    wr_state_d = WrData;
                end
            end
            WrData: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) begin
                    wr_state_d = WrResp;
                end
            end
            WrResp: begin
                b_valid_o = 1'b1;
                if (b_ready_i) begin
                    if (wr_cnt_q != CntMax) begin
                        wr_cnt_d = wr_cnt_q + CntOne;
                    end
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    assign b_id_o   = wr_id_q;
    assign b_resp_o = RESP;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        beat_d     = beat_q;
        rd_cnt_d   = rd_cnt_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;

        unique case (rd_state_q)
            RdIdle: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    rd_id_d    = ar_id_i;
                    beat_d     = ar_len_i;
                    rd_state_d = RdData;
                end
            end
            RdData: begin
                r_valid_o = 1'b1;
                r_last_o  = (beat_q == '0);
                if (r_ready_i) begin
                    if (beat_q == '0) begin
                        if (rd_cnt_q != CntMax) begin
                            rd_cnt_d = rd_cnt_q + CntOne;
                        end
                        rd_state_d = RdIdle;
                    end else begin
                        // Counter never decrements past zero, so len=255 cannot wrap.
                        beat_d = beat_q - 8'd1;
                    end
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    assign r_id_o   = rd_id_q;
    assign r_data_o = RDATA;
    assign r_resp_o = RESP;

    assign wr_err_cnt_o = wr_cnt_q;
    assign rd_err_cnt_o = rd_cnt_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            wr_id_q    <= '0;
            rd_id_q    <= '0;
            beat_q     <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_id_q    <= wr_id_d;
            rd_id_q    <= rd_id_d;
            beat_q     <= beat_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

`ifndef SYNTHESIS
    b_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (b_valid_o && !b_ready_i) |=> (b_valid_o && $stable(b_id_o) && $stable(b_resp_o)));

    r_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_valid_o && !r_ready_i) |=> (r_valid_o && $stable(r_id_o) && $stable(r_data_o)
                                       && $stable(r_resp_o) && $stable(r_last_o)));

    r_last_a: assert property (@(posedge clk_i)
        r_last_o |-> (rd_state_q == RdData && beat_q == '0));
`endif

endmodule
